// File: rtl/btn_pkg.sv
// btn_pkg: shared debounce FSM state encoding and 12 MHz default timing constants
package btn_pkg;
  typedef enum logic [1:0] {RELEASED, PRESS_DB, PRESSED, RELEASE_DB} state_t;
  localparam int DB_20MS = 240000;
  localparam int HOLD_1S = 12000000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchroniser with a reset value, for asynchronous pin inputs
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk) begin
    if (!rst_n) {q, meta} <= {2{RESET_VAL}};
    else {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/button_debounce.sv
// button_debounce: synchronises and debounces a pushbutton pin into a clean level,
// press/release strobes and a one-shot long-press strobe
module button_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DB_20MS,
  parameter int LONG_PRESS_CYCLES = HOLD_1S,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_PRESS_CYCLES - 2);
  state_t state, state_n;
  logic [DW-1:0] db_cnt, db_n;
  logic [HW-1:0] hold_cnt, hold_n, hold_sat;
  logic sync, raw_act;
  sync_2ff #(.RESET_VAL(ACTIVE_LOW)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn_in),
    .q    (sync)
  );
  assign raw_act  = sync ^ ACTIVE_LOW;
  assign hold_sat = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
  always_comb begin
    state_n = state;
    db_n    = db_cnt;
    hold_n  = hold_cnt;
    case (state)
      RELEASED: begin
        db_n   = '0;
        hold_n = '0;
        if (raw_act) state_n = PRESS_DB;
      end
      PRESS_DB: begin
        if (!raw_act) begin
          state_n = RELEASED;
          db_n    = '0;
        end else if (db_cnt == DB_MAX) begin
          state_n = PRESSED;
          db_n    = '0;
          hold_n  = '0;
        end else db_n = db_cnt + 1'b1;
      end
      PRESSED: begin
        db_n   = '0;
        hold_n = hold_sat;
        if (!raw_act) state_n = RELEASE_DB;
      end
      RELEASE_DB: begin
        // the hold timer keeps running here so a release bounce cannot restart it
        if (raw_act) begin
          state_n = PRESSED;
          db_n    = '0;
          hold_n  = hold_sat;
        end else if (db_cnt == DB_MAX) begin
          state_n = RELEASED;
          db_n    = '0;
          hold_n  = '0;
        end else begin
          db_n   = db_cnt + 1'b1;
          hold_n = hold_sat;
        end
      end
      default: state_n = RELEASED;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RELEASED;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
    end else begin
      state       <= state_n;
      db_cnt      <= db_n;
      hold_cnt    <= hold_n;
      btn_level   <= (state_n == PRESSED) || (state_n == RELEASE_DB);
      btn_press   <= (state == PRESS_DB) && (state_n == PRESSED);
      btn_release <= (state == RELEASE_DB) && (state_n == RELEASED);
      btn_long    <= ((state == PRESSED) || (state == RELEASE_DB)) && (hold_cnt == HOLD_PRE);
    end
  end
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: scoreboard bench; strobe events are queued with their expected cycle
// when stimulus is driven and matched against DUT strobes at each falling edge
module tb_button_debounce;
  localparam int PRESS = 1;
  localparam int REL   = 2;
  localparam int LONG  = 3;
  typedef struct {
    int kind;
    int at;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n, btn_in;
  logic btn_level, btn_press, btn_release, btn_long;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int t;
  ev_t q[$];
  button_debounce #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20),
    .ACTIVE_LOW       (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string tag, int got, int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic push(int kind, int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    q.push_back(e);
  endtask
  task automatic take(int kind);
    ev_t e;
    if (q.size() == 0) check("spurious_strobe", kind, 0);
    else begin
      e = q.pop_front();
      check("strobe_kind", kind, e.kind);
      check("strobe_cycle", cyc, e.at);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic level_is(string tag, int exp);
    @(negedge clk);
    check(tag, int'(btn_level), exp);
  endtask
  always @(negedge clk) begin
    if (btn_press && btn_release) check("press_release_excl", 1, 0);
    if (btn_press && btn_long) check("press_long_excl", 1, 0);
    if (btn_press) take(PRESS);
    if (btn_release) take(REL);
    if (btn_long) take(LONG);
  end
  initial begin
    rst_n  = 1'b0;
    btn_in = 1'b0;
    tick(3);
    @(negedge clk);
    check("rst_level", int'(btn_level), 0);
    check("rst_press", int'(btn_press), 0);
    check("rst_release", int'(btn_release), 0);
    check("rst_long", int'(btn_long), 0);
    tick(1);
    rst_n = 1'b1;
    push(PRESS, cyc + 7);
    tick(10);
    level_is("post_rst_level", 1);
    tick(1);
    btn_in = 1'b1;
    push(REL, cyc + 7);
    tick(10);
    level_is("post_rst_release_level", 0);
    tick(1);
    btn_in = 1'b0;
    push(PRESS, cyc + 7);
    tick(10);
    level_is("clean_press_level", 1);
    tick(1);
    btn_in = 1'b1;
    push(REL, cyc + 7);
    tick(10);
    level_is("clean_release_level", 0);
    tick(1);
    for (int i = 0; i < 3; i++) begin
      btn_in = 1'b0;
      tick(2);
      btn_in = 1'b1;
      tick(2);
    end
    tick(10);
    level_is("bounce_level", 0);
    check("bounce_pending", q.size(), 0);
    tick(1);
    btn_in = 1'b0;
    t = cyc;
    push(PRESS, t + 7);
    push(LONG, t + 26);
    tick(10);
    btn_in = 1'b1;
    tick(3);
    btn_in = 1'b0;
    tick(17);
    level_is("long_hold_level", 1);
    tick(1);
    btn_in = 1'b1;
    push(REL, cyc + 7);
    tick(10);
    level_is("long_release_level", 0);
    tick(1);
    btn_in = 1'b0;
    t = cyc;
    push(PRESS, t + 7);
    push(LONG, t + 26);
    tick(28);
    level_is("rearm_level", 1);
    tick(1);
    btn_in = 1'b1;
    push(REL, cyc + 7);
    tick(10);
    level_is("rearm_release_level", 0);
    tick(1);
    btn_in = 1'b0;
    tick(4);
    rst_n = 1'b0;
    tick(1);
    @(negedge clk);
    check("mid_rst_level", int'(btn_level), 0);
    check("mid_rst_press", int'(btn_press), 0);
    tick(1);
    rst_n = 1'b1;
    push(PRESS, cyc + 7);
    tick(10);
    level_is("after_mid_rst_level", 1);
    tick(1);
    btn_in = 1'b1;
    push(REL, cyc + 7);
    tick(10);
    level_is("final_level", 0);
    check("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
